// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: buffers result writes from execution and drains them one
// per cycle onto the register file write port. It also forwards pending values
// so that operand reads never return stale data.
// Optional feature macro: WB_FWD_EN. When it is defined, the pending-write
// forwarding search is built. When it is undefined, the forwarding outputs are
// tied to zero.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        In_Valid,
    output logic                        In_Ready,
    input  logic [AW-1:0]               In_Addr,
    input  logic [DW-1:0]               In_Data,
    input  logic                        Port_Busy,
    input  logic                        Flush,
    output logic [AW-1:0]               W_Addr,
    output logic [DW-1:0]               W_Data,
    output logic                        Write_Reg,
    input  logic [AW-1:0]               Fwd_Addr_A,
    output logic                        Fwd_Hit_A,
    output logic [DW-1:0]               Fwd_Data_A,
    input  logic [AW-1:0]               Fwd_Addr_B,
    output logic                        Fwd_Hit_B,
    output logic [DW-1:0]               Fwd_Data_B,
    output logic [$clog2(DEPTH+2)-1:0]  Pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int NW = $clog2(DEPTH+2);

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    // A full queue refuses a push even when it pops in the same cycle, so ready depends only on count.
    assign In_Ready = (count != CW'(DEPTH));
    // A write to r0 is accepted but discarded. Flush also drops a push made in the same cycle.
    assign do_push  = In_Valid && In_Ready && !Flush && (In_Addr != '0);
    assign do_pop   = (count != '0) && !Port_Busy && !Flush;
    assign Pending  = NW'(count) + NW'(Write_Reg);

    // Queue storage. Its contents are meaningless unless they fall inside the count window, so it has no reset.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            q_addr[wr_ptr] <= In_Addr;
            q_data[wr_ptr] <= In_Data;
        end
    end

    // Pointers, occupancy, and the output stage that feeds the register file write port.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            Write_Reg <= 1'b0;
            W_Addr    <= '0;
            W_Data    <= '0;
        end else if (Flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            Write_Reg <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                W_Addr <= q_addr[rd_ptr];
                W_Data <= q_data[rd_ptr];
            end
            Write_Reg <= do_pop;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

`ifdef WB_FWD_EN
    logic [PW-1:0] idx_a, idx_b;

    // Walk the queue from the oldest entry to the newest, so a later match overrides an earlier one.
    // The output stage is seeded first because it is the oldest pending write.
    always_comb begin
        Fwd_Hit_A  = 1'b0;
        Fwd_Data_A = '0;
        Fwd_Hit_B  = 1'b0;
        Fwd_Data_B = '0;
        idx_a      = '0;
        idx_b      = '0;
        if (Write_Reg && Fwd_Addr_A != '0 && W_Addr == Fwd_Addr_A) begin
            Fwd_Hit_A  = 1'b1;
            Fwd_Data_A = W_Data;
        end
        if (Write_Reg && Fwd_Addr_B != '0 && W_Addr == Fwd_Addr_B) begin
            Fwd_Hit_B  = 1'b1;
            Fwd_Data_B = W_Data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count)) begin
                idx_a = rd_ptr + PW'(i);
                idx_b = rd_ptr + PW'(i);
                if (Fwd_Addr_A != '0 && q_addr[idx_a] == Fwd_Addr_A) begin
                    Fwd_Hit_A  = 1'b1;
                    Fwd_Data_A = q_data[idx_a];
                end
                if (Fwd_Addr_B != '0 && q_addr[idx_b] == Fwd_Addr_B) begin
                    Fwd_Hit_B  = 1'b1;
                    Fwd_Data_B = q_data[idx_b];
                end
            end
        end
    end
`else
    // Without forwarding the consumer stalls on Pending instead, so the lookup addresses are ignored.
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^{Fwd_Addr_A, Fwd_Addr_B};
    assign Fwd_Hit_A  = 1'b0;
    assign Fwd_Data_A = '0;
    assign Fwd_Hit_B  = 1'b0;
    assign Fwd_Data_B = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Testbench for reg_writeback_queue. It runs directed scenarios and then a
// randomized phase. Every cycle is compared against a queue-based reference model.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset, In_Valid, In_Ready, Port_Busy, Flush, Write_Reg;
    logic [4:0]  In_Addr, W_Addr, Fwd_Addr_A, Fwd_Addr_B;
    logic [31:0] In_Data, W_Data, Fwd_Data_A, Fwd_Data_B;
    logic        Fwd_Hit_A, Fwd_Hit_B;
    logic [2:0]  Pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    // Reference model: the queue contents plus the single output stage.
    wr_t         mq[$];
    logic        m_v = 1'b0;
    logic [4:0]  m_a = '0;
    logic [31:0] m_d = '0;

    reg_writeback_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Addr(In_Addr), .In_Data(In_Data), .Port_Busy(Port_Busy), .Flush(Flush),
        .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
        .Fwd_Addr_A(Fwd_Addr_A), .Fwd_Hit_A(Fwd_Hit_A), .Fwd_Data_A(Fwd_Data_A),
        .Fwd_Addr_B(Fwd_Addr_B), .Fwd_Hit_B(Fwd_Hit_B), .Fwd_Data_B(Fwd_Data_B),
        .Pending(Pending)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Find the youngest pending value for an address: queue back to front, then the output stage.
    task automatic fwd_expect(input logic [4:0] fa, output logic hit, output logic [31:0] dat);
        hit = 1'b0;
        dat = '0;
`ifdef WB_FWD_EN
        if (fa != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!hit && mq[i].addr == fa) begin
                    hit = 1'b1;
                    dat = mq[i].data;
                end
            end
            if (!hit && m_v && m_a == fa) begin
                hit = 1'b1;
                dat = m_d;
            end
        end
`endif
    endtask

    task automatic check_outputs();
        logic        h;
        logic [31:0] d;
        chk("in_ready", In_Ready, mq.size() < DEPTH);
        chk("write_reg", Write_Reg, m_v);
        chk("w_addr", W_Addr, m_a);
        chk("w_data", W_Data, m_d);
        chk("pending", Pending, mq.size() + int'(m_v));
        fwd_expect(Fwd_Addr_A, h, d);
        chk("fwd_hit_a", Fwd_Hit_A, h);
        chk("fwd_data_a", Fwd_Data_A, d);
        fwd_expect(Fwd_Addr_B, h, d);
        chk("fwd_hit_b", Fwd_Hit_B, h);
        chk("fwd_data_b", Fwd_Data_B, d);
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic ready, pop, push;
        wr_t  e;
        if (Reset) begin
            mq.delete();
            m_v = 1'b0;
            m_a = '0;
            m_d = '0;
        end else if (Flush) begin
            mq.delete();
            m_v = 1'b0;
        end else begin
            ready = mq.size() < DEPTH;
            pop   = mq.size() > 0 && !Port_Busy;
            push  = In_Valid && ready && In_Addr != 0;
            if (push) begin
                e.addr = In_Addr;
                e.data = In_Data;
                mq.push_back(e);
            end
            if (pop) begin
                e   = mq.pop_front();
                m_a = e.addr;
                m_d = e.data;
            end
            m_v = pop;
        end
    endtask

    task automatic cycle(input logic rst, input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic busy, input logic fl, input logic [4:0] fa, input logic [4:0] fb);
        @(negedge Clk);
        Reset = rst; In_Valid = v; In_Addr = a; In_Data = d;
        Port_Busy = busy; Flush = fl; Fwd_Addr_A = fa; Fwd_Addr_B = fb;
        #1;
        check_outputs();
        @(posedge Clk);
        model_step();
    endtask

    task automatic idle(input int n, input logic busy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, busy, 1'b0, 5'd7, 5'd3);
    endtask

    initial begin
        Reset = 1'b1; In_Valid = 1'b0; In_Addr = '0; In_Data = '0;
        Port_Busy = 1'b0; Flush = 1'b0; Fwd_Addr_A = '0; Fwd_Addr_B = '0;
        repeat (2) @(posedge Clk);
        model_step();

        // Single push: it should drain two cycles later.
        cycle(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 5'd5, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd5, 5'd5);
        idle(3, 1'b0);

        // Fill the queue under Port_Busy, then release it and drain in order.
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 5'(i), 32'hA000 + i, 1'b1, 1'b0, 5'(i), 5'd2);
        idle(6, 1'b0);

        // Two writes to the same register: the younger value must win.
        cycle(1'b0, 1'b1, 5'd7, 32'hA, 1'b1, 1'b0, 5'd7, 5'd0);
        cycle(1'b0, 1'b1, 5'd7, 32'hB, 1'b1, 1'b0, 5'd7, 5'd0);
        idle(2, 1'b1);
        idle(4, 1'b0);

        // A write to r0 is discarded and never hits.
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b0, 5'd0, 5'd0);
        idle(3, 1'b0);

        // Flush with three entries queued and a concurrent push.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5'(9 + i), 32'hB0 + i, 1'b1, 1'b0, 5'd9, 5'd10);
        cycle(1'b0, 1'b1, 5'd12, 32'hCC, 1'b0, 1'b1, 5'd12, 5'd9);
        idle(3, 1'b0);

        // Fill the queue, reset mid-drain, then check that a later push drains normally.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 5'(20 + i), 32'hD0 + i, 1'b1, 1'b0, 5'd20, 5'd21);
        idle(2, 1'b0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd22, 5'd23);
        cycle(1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 5'd22, 5'd6);
        idle(3, 1'b0);

        // Randomized traffic with a small address range, so that forwarding hits are frequent.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7),
                  5'($urandom_range(0, 7)),
                  $urandom,
                  ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 49) == 0),
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
        end
        idle(8, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
